// File: rtl/ptl_pkg.sv
// Shared types and default constants for the PTL receive path.
package ptl_pkg;

  typedef enum logic [1:0] {
    INIT  = 2'd0,
    IDLE  = 2'd1,
    GUARD = 2'd2
  } ptl_state_e;

  localparam int PTL_SYNC_STAGES_DEF  = 2;
  localparam int PTL_BEGIN_CYCLES_DEF = 8;
  localparam int PTL_MIN_GAP_DEF      = 4;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int ptl_cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ptl_sync.sv
// N-stage level synchronizer for an asynchronous single-bit input; resets to 0.
module ptl_sync #(
  parameter int N = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic [N-1:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[N-2:0], d_i};
    end
  end

  assign q_o = sync_q[N-1];

endmodule

// File: rtl/ptl_rx_decoder.sv
// PTL receiver: recovers one pulse per line toggle, with startup blanking and spacing check.
// Optional macro PTL_RX_LEVEL_OUT_EN exposes the retimed toggle level on q_lvl.
module ptl_rx_decoder
  import ptl_pkg::*;
#(
  parameter int SYNC_STAGES  = PTL_SYNC_STAGES_DEF,
  parameter int BEGIN_CYCLES = PTL_BEGIN_CYCLES_DEF,
  parameter int MIN_GAP      = PTL_MIN_GAP_DEF,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             a,
  input  logic             viol_clr,
  output logic             q,
  output logic             ready,
  output logic             viol,
`ifdef PTL_RX_LEVEL_OUT_EN
  output logic             q_lvl,
`endif
  output logic [CNT_W-1:0] pulse_cnt
);

  localparam int BW = ptl_cnt_w(BEGIN_CYCLES);
  localparam int GW = ptl_cnt_w(MIN_GAP);
  localparam logic [BW-1:0] BLANK_LAST = BW'(BEGIN_CYCLES - 1);
  localparam logic [GW-1:0] GAP_LOAD   = GW'(MIN_GAP - 1);

  logic a_s;
  logic trans;

  ptl_state_e       state_q, state_d;
  logic [BW-1:0]    blank_q, blank_d;
  logic [GW-1:0]    gap_q, gap_d;
  logic             ref_q, ref_d;
  logic             pulse_q, pulse_d;
  logic             ready_q, ready_d;
  logic             vpend_q, vpend_d;
  logic             viol_q, viol_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  ptl_sync #(
    .N(SYNC_STAGES)
  ) u_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d_i  (a),
    .q_o  (a_s)
  );

  assign trans = (a_s != ref_q);

  always_comb begin
    state_d = state_q;
    blank_d = blank_q;
    gap_d   = gap_q;
    ref_d   = ref_q;
    pulse_d = 1'b0;
    ready_d = ready_q;
    vpend_d = 1'b0;
    cnt_d   = cnt_q;

    unique case (state_q)
      INIT: begin
        // Whatever level the line settled on during blanking becomes the reference.
        if (blank_q == BLANK_LAST) begin
          ref_d   = a_s;
          ready_d = 1'b1;
          state_d = IDLE;
        end else begin
          blank_d = blank_q + BW'(1);
        end
      end
      IDLE: begin
        if (trans) begin
          pulse_d = 1'b1;
          ref_d   = a_s;
          cnt_d   = cnt_q + CNT_W'(1);
          gap_d   = GAP_LOAD;
          state_d = GUARD;
        end
      end
      GUARD: begin
        if (trans) begin
          pulse_d = 1'b1;
          ref_d   = a_s;
          cnt_d   = cnt_q + CNT_W'(1);
          gap_d   = GAP_LOAD;
          // An expired gap counter means the spacing was exactly MIN_GAP: legal.
          vpend_d = (gap_q != '0);
        end else if (gap_q == '0) begin
          state_d = IDLE;
        end else begin
          gap_d = gap_q - GW'(1);
        end
      end
      default: state_d = INIT;
    endcase
  end

  // The violation is flagged one cycle after its pulse; a pending set beats a clear.
  assign viol_d = vpend_q | (viol_q & ~viol_clr);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= INIT;
      blank_q <= '0;
      gap_q   <= '0;
      ref_q   <= 1'b0;
      pulse_q <= 1'b0;
      ready_q <= 1'b0;
      vpend_q <= 1'b0;
      viol_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      blank_q <= blank_d;
      gap_q   <= gap_d;
      ref_q   <= ref_d;
      pulse_q <= pulse_d;
      ready_q <= ready_d;
      vpend_q <= vpend_d;
      viol_q  <= viol_d;
      cnt_q   <= cnt_d;
    end
  end

  assign q         = pulse_q;
  assign ready     = ready_q;
  assign viol      = viol_q;
  assign pulse_cnt = cnt_q;
`ifdef PTL_RX_LEVEL_OUT_EN
  assign q_lvl     = ref_q;
`endif

endmodule

// File: tb/tb_ptl_rx_decoder.sv
// Self-checking bench for ptl_rx_decoder: directed link scenarios plus random toggles vs a timing model.
module tb_ptl_rx_decoder;

  localparam int S   = 2;
  localparam int B   = 8;
  localparam int G   = 4;
  localparam int CW  = 4;
  localparam int HSZ = 4096;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          a = 1'b0;
  logic          viol_clr = 1'b0;
  logic          q, ready, viol;
  logic [CW-1:0] pulse_cnt;
`ifdef PTL_RX_LEVEL_OUT_EN
  logic          q_lvl;
`endif

  always #5 clk = ~clk;

  ptl_rx_decoder #(
    .SYNC_STAGES (S),
    .BEGIN_CYCLES(B),
    .MIN_GAP     (G),
    .CNT_W       (CW)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .a        (a),
    .viol_clr (viol_clr),
    .q        (q),
    .ready    (ready),
    .viol     (viol),
`ifdef PTL_RX_LEVEL_OUT_EN
    .q_lvl    (q_lvl),
`endif
    .pulse_cnt(pulse_cnt)
  );

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   exp_cnt = 0;
  int   last_pulse = -1000;
  int   q_seen = 0;
  logic exp_viol = 1'b0;
  logic viol_pend = 1'b0;
  logic exp_q, exp_ready, exp_lvl;
  logic a_cur = 1'b0;
  logic a_hist [HSZ];
  logic clr_hist [HSZ];
  logic tog_at [HSZ];

  // Line level during cycle k after reset release; the synchronizer starts from 0.
  function automatic logic ah(input int k);
    return (k < 0) ? 1'b0 : a_hist[k];
  endfunction

  task automatic chk1(input string tag, input logic got, input logic exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s cyc=%0d observed=%b expected=%b", tag, cyc, got, exp);
    end
  endtask

  task automatic chkn(input string tag, input logic [CW-1:0] got, input logic [CW-1:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s cyc=%0d observed=%0d expected=%0d", tag, cyc, got, exp);
    end
  endtask

  task automatic chk_reset_vals();
    chk1("rst_q", q, 1'b0);
    chk1("rst_ready", ready, 1'b0);
    chk1("rst_viol", viol, 1'b0);
    chkn("rst_cnt", pulse_cnt, '0);
`ifdef PTL_RX_LEVEL_OUT_EN
    chk1("rst_q_lvl", q_lvl, 1'b0);
`endif
  endtask

  task automatic model_reset();
    cyc        = 0;
    exp_cnt    = 0;
    last_pulse = -1000;
    exp_viol   = 1'b0;
    viol_pend  = 1'b0;
    for (int i = 0; i < HSZ; i++) begin
      a_hist[i]   = 1'b0;
      clr_hist[i] = 1'b0;
    end
  endtask

  // Drive one cycle, then check the outputs produced by the following edge.
  task automatic tick(input logic av, input logic cv);
    a        = av;
    viol_clr = cv;
    a_hist[cyc]   = av;
    clr_hist[cyc] = cv;
    @(posedge clk);
    #1;
    cyc++;
    exp_q     = (cyc - 1 >= B) && (ah(cyc - 1 - S) != ah(cyc - 2 - S));
    exp_viol  = viol_pend | (exp_viol & ~clr_hist[cyc - 1]);
    viol_pend = exp_q && (cyc - last_pulse < G);
    if (exp_q) begin
      last_pulse = cyc;
      exp_cnt    = (exp_cnt + 1) % (1 << CW);
    end
    exp_ready = (cyc >= B);
    exp_lvl   = (cyc >= B) ? ah(cyc - 1 - S) : 1'b0;
    if (q === 1'b1) q_seen++;
    chk1("q", q, exp_q);
    chk1("ready", ready, exp_ready);
    chk1("viol", viol, exp_viol);
    chkn("pulse_cnt", pulse_cnt, CW'(exp_cnt));
`ifdef PTL_RX_LEVEL_OUT_EN
    chk1("q_lvl", q_lvl, exp_lvl);
`endif
    $display("cyc=%0d a=%b clr=%b q=%b ready=%b viol=%b cnt=%0d", cyc, av, cv, q, ready, viol, pulse_cnt);
  endtask

  initial begin
    int q_base;
    logic cv;

    for (int i = 0; i < HSZ; i++) tog_at[i] = 1'b0;
    tog_at[2] = 1'b1; tog_at[5] = 1'b1;
    tog_at[20] = 1'b1; tog_at[30] = 1'b1; tog_at[40] = 1'b1;
    tog_at[50] = 1'b1; tog_at[52] = 1'b1;
    tog_at[70] = 1'b1; tog_at[71] = 1'b1;
    for (int k = 0; k < 16; k++) tog_at[80 + 5 * k] = 1'b1;

    #1 rst_n = 1'b0;
    #2 chk_reset_vals();
    repeat (3) begin
      @(posedge clk);
      #1 chk_reset_vals();
    end

    model_reset();
    rst_n = 1'b1;
    q_base = 0;
    while (cyc < 170) begin
      if (tog_at[cyc]) a_cur = ~a_cur;
      cv = (cyc == 60) || (cyc >= 70 && cyc <= 74);
      tick(a_cur, cv);
      if (cyc == 20) begin
        chkn("blank_cnt", pulse_cnt, CW'(0));
        chk1("blank_viol", viol, 1'b0);
      end
      if (cyc == 50) chkn("nominal_cnt", pulse_cnt, CW'(3));
      if (cyc == 57) chk1("gap_viol_set", viol, 1'b1);
      if (cyc == 61) chk1("viol_cleared", viol, 1'b0);
      if (cyc == 78) begin
        chk1("clr_set_collision", viol, 1'b1);
        chkn("pre_wrap_cnt", pulse_cnt, CW'(7));
        q_base = q_seen;
      end
    end
    chkn("wrap_cnt", pulse_cnt, CW'(7));
    checks++;
    assert (q_seen - q_base === 16) else begin
      errors++;
      $error("FAIL wrap_pulses observed=%0d expected=16", q_seen - q_base);
    end

    repeat (400) begin
      if ($urandom_range(0, 3) == 0) a_cur = ~a_cur;
      tick(a_cur, ($urandom_range(0, 15) == 0));
    end

    a_cur = ~a_cur;
    tick(a_cur, 1'b0);
    tick(a_cur, 1'b0);
    rst_n = 1'b0;
    #2 chk_reset_vals();
    repeat (3) begin
      @(posedge clk);
      #1 chk_reset_vals();
    end
    model_reset();
    rst_n = 1'b1;
    while (cyc < 40) begin
      if (cyc == 15 || cyc == 25) a_cur = ~a_cur;
      tick(a_cur, 1'b0);
      if (cyc == 7) chk1("reblank_ready", ready, 1'b0);
      if (cyc == 8) chk1("reblank_done", ready, 1'b1);
    end
    chkn("post_reset_cnt", pulse_cnt, CW'(2));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
